// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared pc_src encodings, front-end FSM states and stall timeout default.
package pc_ctrl_pkg;
    localparam logic [2:0] PCSRC_SEQ  = 3'd0;
    localparam logic [2:0] PCSRC_BR   = 3'd1;
    localparam logic [2:0] PCSRC_JMP  = 3'd2;
    localparam logic [2:0] PCSRC_JR   = 3'd3;
    localparam logic [2:0] PCSRC_IRQ  = 3'd4;
    localparam logic [2:0] PCSRC_XADR = 3'd5;
    localparam int STALL_MAX_DEF = 15;
    typedef enum logic [1:0] {RUN, STALL, LDUSE} state_t;
endpackage

// File: rtl/pc_ctrl_stall_timer.sv
// pc_ctrl_stall_timer: counts consecutive hold cycles, flags timeout at stall_max+1 and then restarts.
module pc_ctrl_stall_timer #(
    parameter int STALL_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic hold,
    output logic timeout
);
    localparam int CW = $clog2(STALL_MAX + 2);
    logic [CW-1:0] cnt;
    assign timeout = cnt == CW'(STALL_MAX + 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else
            cnt <= (!hold || timeout) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: PC/IF-ID hazard and redirect control; interrupt support enabled by macro PC_CTRL_IRQ_EN.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int STALL_MAX = STALL_MAX_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mem_wait,
    input  logic       ex_branch,
    input  logic       ex_taken,
    input  logic       id_jump,
    input  logic       id_jr,
    input  logic       id_illegal,
    input  logic       id_load_use,
    input  logic       irq,
    input  logic       pc_kernel,
    output logic       pcifd_wr,
    output logic       cancel,
    output logic       idex_flush,
    output logic [2:0] pc_src,
    output logic       irq_ack,
    output logic       bus_err
);
    state_t state, nxt;
    logic timeout, take_irq;
    pc_ctrl_stall_timer #(.STALL_MAX(STALL_MAX)) u_timer (
        .clk(clk),
        .reset(reset),
        .hold(mem_wait),
        .timeout(timeout)
    );
`ifdef PC_CTRL_IRQ_EN
    logic irq_pending, pend;
    assign pend = irq_pending | irq;
    assign take_irq = pend & ~pc_kernel & ~ex_branch;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            irq_pending <= 1'b0;
        else
            irq_pending <= pend & ~irq_ack;
    end
`else
    logic unused_irq;
    assign unused_irq = irq ^ pc_kernel;
    assign take_irq = 1'b0;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= RUN;
        else
            state <= nxt;
    end
    // Timeout overrides mem_wait; otherwise STALL releases straight into RUN evaluation.
    always_comb begin
        nxt = state;
        pcifd_wr = 1'b1;
        cancel = 1'b0;
        idex_flush = 1'b0;
        pc_src = PCSRC_SEQ;
        irq_ack = 1'b0;
        bus_err = 1'b0;
        if (timeout) begin
            pc_src = PCSRC_XADR;
            cancel = 1'b1;
            idex_flush = 1'b1;
            bus_err = 1'b1;
            nxt = RUN;
        end else if (mem_wait) begin
            pcifd_wr = 1'b0;
            nxt = STALL;
        end else begin
            nxt = RUN;
            if (ex_branch && ex_taken) begin
                pc_src = PCSRC_BR;
                cancel = 1'b1;
                idex_flush = 1'b1;
            end else if (id_illegal) begin
                pc_src = PCSRC_XADR;
                cancel = 1'b1;
                idex_flush = 1'b1;
            end else if (take_irq) begin
                pc_src = PCSRC_IRQ;
                cancel = 1'b1;
                idex_flush = 1'b1;
                irq_ack = 1'b1;
            end else if (id_load_use && state != LDUSE) begin
                pcifd_wr = 1'b0;
                idex_flush = 1'b1;
                nxt = LDUSE;
            end else if (id_jr || id_jump) begin
                pc_src = id_jr ? PCSRC_JR : PCSRC_JMP;
                cancel = 1'b1;
            end
        end
        if (reset) begin
            pcifd_wr = 1'b0;
            cancel = 1'b0;
            idex_flush = 1'b0;
            pc_src = PCSRC_SEQ;
            irq_ack = 1'b0;
            bus_err = 1'b0;
        end
    end
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed vectors with hand-computed outputs for pc_ctrl (STALL_MAX=15).
module tb_pc_ctrl;
    logic clk = 1'b0, reset;
    logic mem_wait, ex_branch, ex_taken, id_jump, id_jr, id_illegal, id_load_use, irq, pc_kernel;
    logic pcifd_wr, cancel, idex_flush, irq_ack, bus_err;
    logic [2:0] pc_src;
    logic [8:0] in_v;
    logic [7:0] o;
    int total = 0, passed = 0;

    localparam logic [8:0] MW = 9'h100, BRN = 9'h080, TKN = 9'h040, JMP_I = 9'h020, JR_I = 9'h010;
    localparam logic [8:0] ILL_I = 9'h008, LU = 9'h004, IRQ_I = 9'h002, KRN = 9'h001;
    // {pcifd_wr, cancel, idex_flush, pc_src[2:0], irq_ack, bus_err}
    localparam logic [7:0] SEQ = 8'h80, STL = 8'h00, BR = 8'hE4, ILL = 8'hF4, BUS = 8'hF5;
    localparam logic [7:0] JR = 8'hCC, JMP = 8'hC8, LDU = 8'h20, ZERO = 8'h00;
`ifdef PC_CTRL_IRQ_EN
    localparam logic [7:0] IRQ_EXP = 8'hF2;
`else
    localparam logic [7:0] IRQ_EXP = 8'h80;
`endif

    assign {mem_wait, ex_branch, ex_taken, id_jump, id_jr, id_illegal, id_load_use, irq, pc_kernel} = in_v;
    assign o = {pcifd_wr, cancel, idex_flush, pc_src, irq_ack, bus_err};

    pc_ctrl #(.STALL_MAX(15)) dut (
        .clk(clk), .reset(reset), .mem_wait(mem_wait), .ex_branch(ex_branch), .ex_taken(ex_taken),
        .id_jump(id_jump), .id_jr(id_jr), .id_illegal(id_illegal), .id_load_use(id_load_use),
        .irq(irq), .pc_kernel(pc_kernel), .pcifd_wr(pcifd_wr), .cancel(cancel),
        .idex_flush(idex_flush), .pc_src(pc_src), .irq_ack(irq_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    endtask

    task automatic vec(input string tag, input logic [8:0] iv, input logic [7:0] exp);
        in_v = iv;
        #3 chk(tag, o, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        in_v = '0;
        #2 chk("rst_idle", o, ZERO);
        in_v = MW | BRN | TKN;
        #1 chk("rst_inputs", o, ZERO);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) vec("idle", '0, SEQ);
        vec("br_jmp", BRN | TKN | JMP_I, BR);
        vec("br_ill", BRN | TKN | ILL_I, BR);
        vec("ill", ILL_I, ILL);
        vec("jr", JR_I, JR);
        vec("jmp", JMP_I, JMP);
        vec("jr_jmp", JR_I | JMP_I, JR);
        vec("br_nt", BRN, SEQ);
        vec("ill_lu", ILL_I | LU, ILL);
        vec("lu_c1", LU, LDU);
        vec("lu_c2", LU, SEQ);
        vec("lu_end", '0, SEQ);
        vec("lu_jr", LU | JR_I, LDU);
        vec("ldu_jr", LU | JR_I, JR);
        vec("post_lu", '0, SEQ);
        for (int i = 1; i <= 16; i++) vec("stall", MW, STL);
        vec("bus_err", MW, BUS);
        for (int i = 0; i < 3; i++) vec("stall_again", MW, STL);
        vec("release", '0, SEQ);
        vec("mw_br1", MW | BRN | TKN, STL);
        vec("mw_br2", MW | BRN | TKN, STL);
        vec("br_reissue", BRN | TKN, BR);
        for (int i = 0; i < 4; i++) vec("pre_rst_stall", MW, STL);
        in_v = MW;
        reset = 1'b1;
        #1 chk("rst_stall5", o, ZERO);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 1; i <= 16; i++) vec("restall", MW, STL);
        vec("bus_err2", MW, BUS);
        vec("lu_r", LU, LDU);
        in_v = LU;
        reset = 1'b1;
        #1 chk("rst_ldu", o, ZERO);
        @(posedge clk);
        #1 reset = 1'b0;
        vec("after_rst", '0, SEQ);
        vec("k_irq", IRQ_I | KRN, SEQ);
        for (int i = 0; i < 4; i++) vec("k_wait", KRN, SEQ);
        vec("irq_take", '0, IRQ_EXP);
        vec("irq_once", '0, SEQ);
        vec("irq_br", IRQ_I | BRN, SEQ);
        vec("irq_defer", '0, IRQ_EXP);
        vec("irq_done", '0, SEQ);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
